// File: rtl/comp_page_scheduler_pkg.sv
// Shared types and constants for the compression page scheduler.
package comp_page_scheduler_pkg;

  localparam int COMP_CORES = 4;
  localparam int PAGE_SIZE  = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/comp_page_scheduler_rr_idle_picker.sv
// Combinational round-robin first-idle core selector, scanning upward from ptr.
// Zero latency; no flow control of its own.
module rr_idle_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  busy,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan farthest-to-nearest so the core closest to ptr is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (!busy[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/comp_page_scheduler.sv
// Splits one job into page read requests dispatched round-robin to idle cores; counts completions.
// Latency: start at t -> first request at t+1; a stalled request holds its payload until ready.
module comp_page_scheduler
  import comp_page_scheduler_pkg::*;
#(
  parameter int N_CORES    = COMP_CORES,
  parameter int PAGE_BITS  = $clog2(PAGE_SIZE),
  parameter int VADDR_BITS = 48,
  parameter int CNT_BITS   = 32,
  parameter int CORE_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [VADDR_BITS-1:0] base_vaddr,
  input  logic [CNT_BITS-1:0]   n_pages,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_BITS-1:0]   cycles,
  output logic                  err_unexp,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [VADDR_BITS-1:0] rd_req_vaddr,
  output logic [PAGE_BITS:0]    rd_req_len,
  output logic [CORE_W-1:0]     rd_req_core,
  input  logic [N_CORES-1:0]    core_done,
  output logic [N_CORES-1:0]    core_busy
);

  sched_state_t          state_q, state_d;
  logic [VADDR_BITS-1:0] vaddr_q;
  logic [CNT_BITS-1:0]   n_pages_q, issued_q, completed_q, cycles_q;
  logic                  err_q;
  logic [N_CORES-1:0]    core_busy_q;
  logic [CORE_W-1:0]     rr_ptr_q, hold_core_q;
  logic                  hold_q;

  logic [CORE_W-1:0]     pick_idx, sel_core, rr_next;
  logic                  pick_found, start_acc, hs, last_issue, unexp, cnt_en;
  logic [N_CORES-1:0]    done_hits, grant;
  logic [CNT_BITS-1:0]   done_cnt;
  logic [VADDR_BITS-1:0] page_step;

  rr_idle_picker #(.N(N_CORES), .IW(CORE_W)) u_picker (
    .busy  (core_busy_q),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A stalled request keeps its core even if a lower-index core frees up meanwhile.
  assign sel_core     = hold_q ? hold_core_q : pick_idx;
  assign rd_req_valid = (state_q == ISSUE) && (hold_q || pick_found);
  assign hs           = rd_req_valid && rd_req_ready;
  assign start_acc    = start && (state_q == IDLE);
  assign last_issue   = hs && ((issued_q + CNT_BITS'(1)) == n_pages_q);
  assign cnt_en       = (state_q == ISSUE) || (state_q == DRAIN);
  assign rr_next      = (sel_core == CORE_W'(N_CORES - 1)) ? '0 : sel_core + CORE_W'(1);
  assign page_step    = {{(VADDR_BITS-PAGE_BITS-1){1'b0}}, 1'b1, {PAGE_BITS{1'b0}}};
  assign grant        = hs ? ({{(N_CORES-1){1'b0}}, 1'b1} << sel_core) : '0;

  // Completions from a previous job are meaningless once back in IDLE.
  assign done_hits = (state_q == IDLE) ? '0 : (core_done & core_busy_q);
  assign unexp     = (state_q != IDLE) && (|(core_done & ~core_busy_q));

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < N_CORES; i++) begin
      done_cnt = done_cnt + CNT_BITS'(done_hits[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_pages == '0) ? FIN : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (completed_q == n_pages_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      vaddr_q     <= '0;
      n_pages_q   <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      cycles_q    <= '0;
      err_q       <= 1'b0;
      core_busy_q <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      hold_core_q <= '0;
    end else begin
      state_q     <= state_d;
      core_busy_q <= (core_busy_q & ~done_hits) | grant;
      if (start_acc) begin
        vaddr_q     <= base_vaddr;
        n_pages_q   <= n_pages;
        issued_q    <= '0;
        completed_q <= '0;
        err_q       <= 1'b0;
        hold_q      <= 1'b0;
        // An empty job never passes through ISSUE/DRAIN; its single FIN cycle is the elapsed time.
        cycles_q    <= (n_pages == '0) ? CNT_BITS'(1) : '0;
      end else begin
        if (unexp) err_q <= 1'b1;
        completed_q <= completed_q + done_cnt;
        if (cnt_en && (cycles_q != '1)) cycles_q <= cycles_q + CNT_BITS'(1);
        if (hs) begin
          vaddr_q  <= vaddr_q + page_step;
          issued_q <= issued_q + CNT_BITS'(1);
          rr_ptr_q <= rr_next;
          hold_q   <= 1'b0;
        end else if (rd_req_valid) begin
          hold_q      <= 1'b1;
          hold_core_q <= sel_core;
        end
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign cycles       = cycles_q;
  assign err_unexp    = err_q;
  assign rd_req_vaddr = vaddr_q;
  assign rd_req_len   = {1'b1, {PAGE_BITS{1'b0}}};
  assign rd_req_core  = sel_core;
  assign core_busy    = core_busy_q;

endmodule
